vga_pixel_feeder: RTL
=====================

Name: vga_pixel_feeder

Overview:
- Source side of the VGA colour path: prefetches 12-bit pixel words from frame memory over a req/ack handshake into a small FIFO.
- Presents one word per active pixel on Data, timed so the VGA colour stage (which registers its active flag) sees the correct pixel.
- Sits between the frame-memory arbiter and the VGA colour-assign stage.
- Shares the counters and margin values produced by the VGA config/counter unit.

Parameters:
- DATA_WIDTH, 12, pixel word width ({B,G,R} 4 bits each).
- REZ_MAX_WIDTH, 11, width of the counters and margins.
- ADDR_WIDTH, 19, frame-memory word address width.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16.

Ports:
- Clk  in  1  pixel clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-low reset (Rst=0 at a rising edge resets).
- Count_h  in  REZ_MAX_WIDTH  horizontal pixel counter.
- Count_v  in  REZ_MAX_WIDTH  vertical line counter.
- H_left_margin  in  REZ_MAX_WIDTH  first active column (inclusive).
- H_right_margin  in  REZ_MAX_WIDTH  last active column (inclusive).
- V_left_margin  in  REZ_MAX_WIDTH  first active line (inclusive).
- V_right_margin  in  REZ_MAX_WIDTH  last active line (inclusive).
- Mem_req  out  1  read request to frame memory.
- Mem_addr  out  ADDR_WIDTH  word address; valid while Mem_req=1.
- Mem_ack  in  1  request accepted; Mem_data valid in the same cycle.
- Mem_data  in  DATA_WIDTH  read data.
- Data  out  DATA_WIDTH  pixel word to the colour-assign stage.
- Underflow  out  1  sticky: the FIFO was empty when a pixel was needed.
- Frame_start  out  1  one-cycle pulse when a frame resync occurs.

Behaviour:
Reset:
- Data=0, Mem_req=0, Mem_addr=0, Underflow=0, Frame_start=0.
- FIFO empty; fetch count 0; state IDLE.
- Reset mid-transaction drops Mem_req immediately and discards any in-flight data.

Derived signals:
- Active = Count_h within [H_left_margin, H_right_margin] AND Count_v within [V_left_margin, V_right_margin], combinational, inclusive bounds.
- Sof = (Count_h==0 && Count_v==0).

Pixel output:
- In a cycle with Active=1, pop the FIFO head into Data at the next edge (1-cycle latency).
- In a cycle with Active=0, Data<=0.
- If Active=1 and the FIFO is empty: Data<=0, Underflow<=1. Underflow clears only on reset.

Frame size:
- At each Sof, latch Frame_pix = (H_right_margin-H_left_margin+1)*(V_right_margin-V_left_margin+1), truncated to ADDR_WIDTH.
- Margins with right<left give Frame_pix=0: nothing is fetched and every active pixel underflows.

Memory handshake:
- At most one outstanding request.
- Once Mem_req=1, Mem_req and Mem_addr stay stable until the cycle Mem_ack=1.
- In the ack cycle the word is written into the FIFO (unless discarding), Mem_addr increments, and Mem_req may reassert on the next cycle (no back-to-back requirement).
- Mem_ack while Mem_req=0 is ignored.

Request rule:
- Issue a request when: state is FILL or RUN, FIFO count + outstanding < 16, and fetch count < Frame_pix.

FIFO:
- Push and pop in the same cycle are both honoured; count is unchanged.
- Push when full cannot occur, because the request rule prevents it.

State machine:
- IDLE: no fetch. On Sof -> FILL, pulse Frame_start.
- FILL: fetch until the FIFO is full or Active first asserts -> RUN.
- RUN: fetch and pop continuously.
- RESYNC: entered from FILL or RUN on Sof while a request is outstanding. Mem_req is held until ack; that word is discarded. On ack -> FILL.

Actions on Sof from FILL or RUN:
- Flush the FIFO; fetch count and Mem_addr reset to 0; pulse Frame_start.
- With no request outstanding, go straight to FILL.
- Sof while in RESYNC only re-pulses Frame_start.

Wrap-around:
- Mem_addr never exceeds Frame_pix-1 within a frame and returns to 0 only at Sof.

Test Plan:
- Margins H 10..13, V 2..3; memory acks 1 cycle after req with data = address -> after Sof, exactly 8 requests (addr 0..7); Data shows 0,1,2,3 on the cycles after Count_h=10..13 of line 2, then 4..7 on line 3; Underflow stays 0.
- Same frame; memory holds ack low for 40 cycles per request -> first active pixel finds the FIFO empty: Data=0 and Underflow=1 sticky through the next frame.
- Margins H 0..99, V 0..0; ack immediate -> FIFO count peaks at 16, never 17; Mem_req drops while full and resumes after the first pop.
- Sof asserted while Mem_req=1 at addr 5 with ack delayed 3 cycles -> Mem_addr holds 5 until ack; that word is not pushed; next request uses addr 0; Frame_start pulses once.
- Rst=0 for one edge mid-RUN with Mem_req=1 -> the next cycle shows Mem_req=0, Data=0, Underflow=0, state IDLE; no fetch until the next Sof.
- Margins H 20..10 (inverted) -> Frame_pix=0, zero requests issued, Data stays 0.

Source files
------------

// File: rtl/vga_pixel_feeder.sv
// Purpose : prefetch 12-bit pixel words from frame memory into a 16-deep FIFO and present one word per active pixel.
// Latency : Data carries the FIFO head one clock after the cycle whose counters are active.
// Backpress: fetching stops while FIFO count + outstanding reaches 16 or the frame's word count is met.
//
// Ports: Clk/Rst (sync, active-low); Count_h/Count_v and the four inclusive margins from the counter unit;
//        Mem_req/Mem_addr/Mem_ack/Mem_data read handshake (one request outstanding at most);
//        Data pixel word, Underflow sticky starvation flag, Frame_start one-cycle resync pulse.
module vga_pixel_feeder #(
    parameter int DATA_WIDTH    = 12,
    parameter int REZ_MAX_WIDTH = 11,
    parameter int ADDR_WIDTH    = 19,
    parameter int FIFO_AW       = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [REZ_MAX_WIDTH-1:0] Count_h,
    input  logic [REZ_MAX_WIDTH-1:0] Count_v,
    input  logic [REZ_MAX_WIDTH-1:0] H_left_margin,
    input  logic [REZ_MAX_WIDTH-1:0] H_right_margin,
    input  logic [REZ_MAX_WIDTH-1:0] V_left_margin,
    input  logic [REZ_MAX_WIDTH-1:0] V_right_margin,
    output logic                     Mem_req,
    output logic [ADDR_WIDTH-1:0]    Mem_addr,
    input  logic                     Mem_ack,
    input  logic [DATA_WIDTH-1:0]    Mem_data,
    output logic [DATA_WIDTH-1:0]    Data,
    output logic                     Underflow,
    output logic                     Frame_start
);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_RESYNC} state_t;

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int SPW   = REZ_MAX_WIDTH + 1;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   fifo_q [DEPTH];
    logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]        count_q, count_d;
    logic                    mem_req_q, mem_req_d;
    // Mem_addr doubles as the per-frame fetch count: it only advances on accepted words.
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_WIDTH-1:0]   frame_pix_q, frame_pix_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    underflow_q, underflow_d;
    logic                    frame_start_q, frame_start_d;

    logic                    active, sof, fetching, ack, flush, push, pop;
    logic [SPW-1:0]          h_span, v_span;
    logic [2*SPW-1:0]        pix_prod;

    // Inverted margins yield a zero span, hence a zero word count for the frame.
    always_comb begin
        h_span = '0;
        v_span = '0;
        if (H_right_margin >= H_left_margin)
            h_span = {1'b0, H_right_margin} - {1'b0, H_left_margin} + SPW'(1);
        if (V_right_margin >= V_left_margin)
            v_span = {1'b0, V_right_margin} - {1'b0, V_left_margin} + SPW'(1);
        pix_prod = {{SPW{1'b0}}, h_span} * {{SPW{1'b0}}, v_span};
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        frame_pix_d   = frame_pix_q;
        data_d        = '0;
        underflow_d   = underflow_q;
        frame_start_d = 1'b0;

        active   = (Count_h >= H_left_margin) && (Count_h <= H_right_margin) &&
                   (Count_v >= V_left_margin) && (Count_v <= V_right_margin);
        sof      = (Count_h == '0) && (Count_v == '0);
        fetching = (state_q == ST_FILL) || (state_q == ST_RUN);
        ack      = mem_req_q && Mem_ack;
        flush    = fetching && sof;
        // Words arriving in RESYNC, or in the flush cycle itself, belong to the old frame.
        push     = ack && fetching && !flush;
        // No bypass: a word pushed this cycle is not visible to a pop in the same cycle.
        pop      = active && (count_q != '0);

        if (pop)
            data_d = fifo_q[rd_ptr_q];
        if (active && (count_q == '0))
            underflow_d = 1'b1;

        frame_start_d = sof;
        if (sof)
            frame_pix_d = ADDR_WIDTH'(pix_prod);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            if (push && !pop)
                count_d = count_q + (FIFO_AW + 1)'(1);
            else if (!push && pop)
                count_d = count_q - (FIFO_AW + 1)'(1);
        end

        // With no request in flight, count_q alone is "count + outstanding".
        if (mem_req_q) begin
            if (ack) begin
                mem_req_d = 1'b0;
                if (push)
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
            end
        end else if (fetching && !sof && (count_q < FULL_CNT) && (mem_addr_q < frame_pix_q)) begin
            mem_req_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sof)
                    state_d = ST_FILL;
            end
            ST_FILL, ST_RUN: begin
                if (sof) begin
                    // An unanswered request must keep its address until acked.
                    if (mem_req_q && !Mem_ack) begin
                        state_d = ST_RESYNC;
                    end else begin
                        state_d    = ST_FILL;
                        mem_addr_d = '0;
                    end
                end else if ((state_q == ST_FILL) && ((count_q == FULL_CNT) || active)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RESYNC: begin
                if (ack) begin
                    state_d    = ST_FILL;
                    mem_addr_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            frame_pix_q   <= '0;
            data_q        <= '0;
            underflow_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            frame_pix_q   <= frame_pix_d;
            data_q        <= data_d;
            underflow_q   <= underflow_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst && push)
            fifo_q[wr_ptr_q] <= Mem_data;
    end

    assign Mem_req     = mem_req_q;
    assign Mem_addr    = mem_addr_q;
    assign Data        = data_q;
    assign Underflow   = underflow_q;
    assign Frame_start = frame_start_q;

endmodule
